// File: rtl/pipelined_inst_decoder_pkg.sv
// Shared decode types and MIPS opcode/function constants for the pipelined decoder.
package decoder_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_COP0  = 6'b010000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FUN_SLL   = 6'b000000;
  localparam logic [5:0] FUN_SRL   = 6'b000010;
  localparam logic [5:0] FUN_SRA   = 6'b000011;
  localparam logic [5:0] FUN_JR    = 6'b001000;
  localparam logic [5:0] FUN_JALR  = 6'b001001;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]  af;
    logic        i;
    logic        alu_mux_sel;
    logic [4:0]  cad;
    logic        gp_we;
    logic [1:0]  gp_mux_sel;
    logic [3:0]  bf;
    logic        dm_we;
    logic [2:0]  shift_type;
    logic [1:0]  pc_mux_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] iindex;
  } dec_bundle_t;

  // R-type functions whose GPR write data comes from the shifter path.
  function automatic logic fun_is_shift_wb(input logic [5:0] fun);
    case (fun)
      6'd0, 6'd1, 6'd2, 6'd4, 6'd6, 6'd7: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_inst_decoder_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage, plus stall counter and FSM state.
interface pipelined_inst_decoder_if #(parameter int CNT_W = 16);
  import decoder_pkg::*;

  // Handshake: a beat transfers on a cycle where valid & ready are both high; a
  // producer holding valid keeps its payload stable until that cycle.
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_af;
  logic              out_i;
  logic              out_alu_mux_sel;
  logic [4:0]        out_cad;
  logic              out_gp_we;
  logic [1:0]        out_gp_mux_sel;
  logic [3:0]        out_bf;
  logic              out_dm_we;
  logic [2:0]        out_shift_type;
  logic [1:0]        out_pc_mux_sel;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_sa;
  logic [15:0]       out_imm;
  logic [25:0]       out_iindex;
  logic [CNT_W-1:0]  stall_cnt;
  state_e            dbg_state;

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_af, out_i, out_alu_mux_sel, out_cad, out_gp_we,
           out_gp_mux_sel, out_bf, out_dm_we, out_shift_type, out_pc_mux_sel,
           out_rs, out_rt, out_sa, out_imm, out_iindex, stall_cnt, dbg_state
  );

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_af, out_i, out_alu_mux_sel, out_cad, out_gp_we,
           out_gp_mux_sel, out_bf, out_dm_we, out_shift_type, out_pc_mux_sel,
           out_rs, out_rt, out_sa, out_imm, out_iindex, stall_cnt, dbg_state
  );

endinterface

// File: rtl/inst_decode_comb.sv
// Pure combinational MIPS decode of one instruction word into the control bundle.
module inst_decode_comb
  import decoder_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_bundle_t dec_o,
  output logic        reads_rt_o,
  output logic        is_lw_o
);

  logic [5:0] opc;
  logic [5:0] fun;
  logic       rtype;
  logic       jtype;
  logic       itype;

  assign opc   = instr_i[31:26];
  assign fun   = instr_i[5:0];
  assign rtype = (opc == OPC_RTYPE) | (opc == OPC_COP0);
  assign jtype = (opc[5:1] == 5'b00001);
  assign itype = !rtype & !jtype;

  assign reads_rt_o = rtype | (opc == OPC_SW) | (opc[5:3] == 3'b000);
  assign is_lw_o    = (opc == OPC_LW);

  always_comb begin
    dec_o             = '0;
    dec_o.rs          = instr_i[25:21];
    dec_o.rt          = instr_i[20:16];
    dec_o.sa          = instr_i[10:6];
    dec_o.imm         = instr_i[15:0];
    dec_o.iindex      = instr_i[25:0];
    dec_o.af[2:0]     = rtype ? fun[2:0] : opc[2:0];
    dec_o.af[3]       = rtype ? fun[3] : (opc[2] & opc[1]);
    dec_o.i           = itype & (opc[5:3] == 3'b001);
    dec_o.alu_mux_sel = rtype & (fun[5:4] == 2'b10);
    dec_o.shift_type  = {1'b0, fun[1:0]};
    dec_o.bf          = {opc[2:0], instr_i[16]};
    dec_o.dm_we       = (opc == OPC_SW);

    if (opc == OPC_JAL)  dec_o.cad = 5'd31;
    else if (rtype)      dec_o.cad = instr_i[15:11];
    else                 dec_o.cad = instr_i[20:16];

    dec_o.gp_we = (opc[5:3] == 3'b100) | dec_o.i | dec_o.alu_mux_sel | (opc == OPC_JAL) |
                  (rtype & ((fun == FUN_JALR) | (fun == FUN_SRL) | (fun == FUN_SRA) | (fun == FUN_SLL)));

    if (dec_o.alu_mux_sel | dec_o.i)         dec_o.gp_mux_sel = 2'b00;
    else if (opc == OPC_LW)                  dec_o.gp_mux_sel = 2'b01;
    else if (rtype & fun_is_shift_wb(fun))   dec_o.gp_mux_sel = 2'b10;
    else                                     dec_o.gp_mux_sel = 2'b11;

    if (rtype & (fun[5:2] == 4'b0010))       dec_o.pc_mux_sel = 2'b00;
    else if (itype & (opc[5:3] == 3'b000))   dec_o.pc_mux_sel = 2'b01;
    else if (jtype)                          dec_o.pc_mux_sel = 2'b10;
    else                                     dec_o.pc_mux_sel = 2'b11;
  end

endmodule

// File: rtl/pipelined_inst_decoder.sv
// Registered MIPS decode stage with load-use bubble insertion, flush and stall counter.
// Optional macro ID_SKID_BUF_EN adds a one-entry skid buffer and a registered in_ready.
module pipelined_inst_decoder
  import decoder_pkg::*;
#(
  parameter int HAZARD_BUBBLES = 1,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_inst_decoder_if.slave bus
);

  localparam logic [1:0] BUB_INIT = (HAZARD_BUBBLES > 0) ? 2'(HAZARD_BUBBLES - 1) : 2'd0;

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic             out_valid_q;
  logic             held_lw_q;
  dec_bundle_t      bundle_q;
  logic [CNT_W-1:0] stall_cnt_q;

  dec_bundle_t in_dec;
  logic        in_reads_rt;
  logic        in_is_lw;
  dec_bundle_t head_dec;
  logic        head_reads_rt;
  logic        head_is_lw;
  logic        head_valid;
  logic        hazard;
  logic        can_load;
  logic        load;

  inst_decode_comb u_dec_in (
    .instr_i    (bus.in_instr),
    .dec_o      (in_dec),
    .reads_rt_o (in_reads_rt),
    .is_lw_o    (in_is_lw)
  );

`ifdef ID_SKID_BUF_EN
  logic        skid_valid_q;
  logic        skid_valid_d;
  logic [31:0] skid_instr_q;
  logic        in_ready_q;
  logic        in_take;
  dec_bundle_t skid_dec;
  logic        skid_reads_rt;
  logic        skid_is_lw;

  inst_decode_comb u_dec_skid (
    .instr_i    (skid_instr_q),
    .dec_o      (skid_dec),
    .reads_rt_o (skid_reads_rt),
    .is_lw_o    (skid_is_lw)
  );

  // The parked beat is always older than anything on the input, so it issues first.
  assign in_take       = bus.in_valid & in_ready_q & !bus.flush;
  assign head_valid    = skid_valid_q | in_take;
  assign head_dec      = skid_valid_q ? skid_dec      : in_dec;
  assign head_reads_rt = skid_valid_q ? skid_reads_rt : in_reads_rt;
  assign head_is_lw    = skid_valid_q ? skid_is_lw    : in_is_lw;
  assign bus.in_ready  = in_ready_q & !bus.flush;

  always_comb begin
    skid_valid_d = skid_valid_q;
    if (bus.flush)         skid_valid_d = 1'b0;
    else if (skid_valid_q) skid_valid_d = !load;
    else                   skid_valid_d = in_take & !load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
      if (in_take && !load && !skid_valid_q) skid_instr_q <= bus.in_instr;
    end
  end
`else
  assign head_valid    = bus.in_valid;
  assign head_dec      = in_dec;
  assign head_reads_rt = in_reads_rt;
  assign head_is_lw    = in_is_lw;
  assign bus.in_ready  = can_load;
`endif

  assign hazard = (HAZARD_BUBBLES > 0) & out_valid_q & held_lw_q & (bundle_q.cad != 5'd0) &
                  head_valid & ((head_dec.rs == bundle_q.cad) |
                                (head_reads_rt & (head_dec.rt == bundle_q.cad)));

  assign can_load = (state_q == RUN) & (!out_valid_q | bus.out_ready) & !hazard & !bus.flush;
  assign load     = can_load & head_valid;

  // Flush wins over everything; a hazard with a stalled consumer just holds the load in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      held_lw_q   <= 1'b0;
      bundle_q    <= '0;
      stall_cnt_q <= '0;
    end else if (bus.flush) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= BUBBLE;
            cnt_q       <= BUB_INIT;
          end else if (load) begin
            bundle_q    <= head_dec;
            held_lw_q   <= head_is_lw;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        BUBBLE: begin
          if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_q <= stall_cnt_q + 1'b1;
          if (cnt_q == 2'd0) state_q <= RUN;
          else               cnt_q   <= cnt_q - 2'd1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_af          = bundle_q.af;
  assign bus.out_i           = bundle_q.i;
  assign bus.out_alu_mux_sel = bundle_q.alu_mux_sel;
  assign bus.out_cad         = bundle_q.cad;
  assign bus.out_gp_we       = bundle_q.gp_we;
  assign bus.out_gp_mux_sel  = bundle_q.gp_mux_sel;
  assign bus.out_bf          = bundle_q.bf;
  assign bus.out_dm_we       = bundle_q.dm_we;
  assign bus.out_shift_type  = bundle_q.shift_type;
  assign bus.out_pc_mux_sel  = bundle_q.pc_mux_sel;
  assign bus.out_rs          = bundle_q.rs;
  assign bus.out_rt          = bundle_q.rt;
  assign bus.out_sa          = bundle_q.sa;
  assign bus.out_imm         = bundle_q.imm;
  assign bus.out_iindex      = bundle_q.iindex;
  assign bus.stall_cnt       = stall_cnt_q;
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_pipelined_inst_decoder.sv
// Directed bench for pipelined_inst_decoder built with HAZARD_BUBBLES=2.
module tb_pipelined_inst_decoder;
  import decoder_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipelined_inst_decoder_if #(.CNT_W(16)) bus();

  pipelined_inst_decoder #(.HAZARD_BUBBLES(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_LW2   = 32'h8C220004; // lw   $2,4($1)
  localparam logic [31:0] I_LW0   = 32'h8C200004; // lw   $0,4($1)
  localparam logic [31:0] I_ADD   = 32'h00432020; // add  $4,$2,$3
  localparam logic [31:0] I_ADD0  = 32'h00032020; // add  $4,$0,$3
  localparam logic [31:0] I_SW    = 32'hAC430008; // sw   $3,8($2)
  localparam logic [31:0] I_JAL   = 32'h0C000010; // jal  0x10
  localparam logic [31:0] I_SLL   = 32'h000628C0; // sll  $5,$6,3
  localparam logic [31:0] I_ADDI  = 32'h2027FFFF; // addi $7,$1,-1
  localparam logic [31:0] I_BEQ   = 32'h10220003; // beq  $1,$2,3
  localparam logic [31:0] I_JR    = 32'h03E00008; // jr   $31

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    bus.in_valid  = 1'b1;
    bus.in_instr  = w;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_cad",       32'(bus.out_cad), 32'd0);
    chk("rst_state",     32'(bus.dbg_state), 32'(RUN));
    rst_n = 1'b1;
    step();

    // Decode patterns, one beat each with a free-running consumer.
    send(I_SLL);
    chk("sll_valid",    32'(bus.out_valid), 32'd1);
    chk("sll_cad",      32'(bus.out_cad), 32'd5);
    chk("sll_sa",       32'(bus.out_sa), 32'd3);
    chk("sll_gp_we",    32'(bus.out_gp_we), 32'd1);
    chk("sll_gp_mux",   32'(bus.out_gp_mux_sel), 32'd2);
    chk("sll_alu_mux",  32'(bus.out_alu_mux_sel), 32'd0);
    chk("sll_pc_mux",   32'(bus.out_pc_mux_sel), 32'd3);

    send(I_ADDI);
    chk("addi_i",       32'(bus.out_i), 32'd1);
    chk("addi_cad",     32'(bus.out_cad), 32'd7);
    chk("addi_gp_mux",  32'(bus.out_gp_mux_sel), 32'd0);
    chk("addi_imm",     32'(bus.out_imm), 32'hFFFF);
    chk("addi_af",      32'(bus.out_af), 32'd0);

    send(I_BEQ);
    chk("beq_pc_mux",   32'(bus.out_pc_mux_sel), 32'd1);
    chk("beq_bf",       32'(bus.out_bf), 32'h8);
    chk("beq_af",       32'(bus.out_af), 32'h4);
    chk("beq_gp_we",    32'(bus.out_gp_we), 32'd0);

    send(I_JR);
    chk("jr_pc_mux",    32'(bus.out_pc_mux_sel), 32'd0);
    chk("jr_gp_we",     32'(bus.out_gp_we), 32'd0);
    chk("jr_rs",        32'(bus.out_rs), 32'd31);
    step();
    chk("drain_valid",  32'(bus.out_valid), 32'd0);

    // Load-use hazard: lw $2 followed by add reading $2.
    bus.in_valid = 1'b1; bus.in_instr = I_LW2; bus.out_ready = 1'b0;
    #1;
    chk("lw_in_ready",  32'(bus.in_ready), 32'd1);
    step();
    chk("lw_valid",     32'(bus.out_valid), 32'd1);
    chk("lw_gp_mux",    32'(bus.out_gp_mux_sel), 32'd1);
    chk("lw_cad",       32'(bus.out_cad), 32'd2);
    chk("lw_gp_we",     32'(bus.out_gp_we), 32'd1);
    chk("lw_i",         32'(bus.out_i), 32'd0);
    chk("lw_af",        32'(bus.out_af), 32'h3);
    bus.in_instr = I_ADD; bus.out_ready = 1'b1;
    #1;
    chk("haz_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("bub1_state",   32'(bus.dbg_state), 32'(BUBBLE));
    chk("bub1_valid",   32'(bus.out_valid), 32'd0);
    chk("bub1_ready",   32'(bus.in_ready), 32'd0);
    step();
    chk("bub2_valid",   32'(bus.out_valid), 32'd0);
    chk("bub2_ready",   32'(bus.in_ready), 32'd0);
    chk("bub2_stall",   32'(bus.stall_cnt), 32'd1);
    step();
    chk("bub_end_state", 32'(bus.dbg_state), 32'(RUN));
    chk("bub_end_stall", 32'(bus.stall_cnt), 32'd2);
    chk("bub_end_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("add_valid",    32'(bus.out_valid), 32'd1);
    chk("add_cad",      32'(bus.out_cad), 32'd4);
    chk("add_alu_mux",  32'(bus.out_alu_mux_sel), 32'd1);
    chk("add_gp_mux",   32'(bus.out_gp_mux_sel), 32'd0);
    step();

    // lw targeting $0 never creates a hazard.
    send(I_LW0);
    chk("lw0_cad",      32'(bus.out_cad), 32'd0);
    bus.in_valid = 1'b1; bus.in_instr = I_ADD0;
    #1;
    chk("lw0_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("lw0_add_cad",  32'(bus.out_cad), 32'd4);
    chk("lw0_stall",    32'(bus.stall_cnt), 32'd2);
    chk("lw0_state",    32'(bus.dbg_state), 32'(RUN));
    step();

    // Consumer stall: bundle held stable, no input accepted.
    bus.in_valid = 1'b1; bus.in_instr = I_SW; bus.out_ready = 1'b0;
    step();
    bus.in_instr = I_JAL;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_ready", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d_dm_we", k), 32'(bus.out_dm_we), 32'd1);
      chk($sformatf("stall%0d_imm", k),   32'(bus.out_imm), 32'd8);
      step();
    end
    chk("sw_gp_we",     32'(bus.out_gp_we), 32'd0);
    chk("sw_cad",       32'(bus.out_cad), 32'd3);
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("jal_cad",      32'(bus.out_cad), 32'd31);
    chk("jal_pc_mux",   32'(bus.out_pc_mux_sel), 32'd2);
    chk("jal_gp_we",    32'(bus.out_gp_we), 32'd1);
    chk("jal_iindex",   32'(bus.out_iindex), 32'h10);
    chk("jal_gp_mux",   32'(bus.out_gp_mux_sel), 32'd3);
    step();

    // Flush while in BUBBLE.
    send(I_LW2);
    bus.in_valid = 1'b1; bus.in_instr = I_ADD;
    step();
    chk("fl_bub_state", 32'(bus.dbg_state), 32'(BUBBLE));
    bus.flush = 1'b1;
    #1;
    chk("fl_in_ready",  32'(bus.in_ready), 32'd0);
    step();
    bus.flush = 1'b0;
    #1;
    chk("fl_state",     32'(bus.dbg_state), 32'(RUN));
    chk("fl_valid",     32'(bus.out_valid), 32'd0);
    chk("fl_ready",     32'(bus.in_ready), 32'd1);
    chk("fl_stall",     32'(bus.stall_cnt), 32'd2);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("fl_add_valid", 32'(bus.out_valid), 32'd1);
    chk("fl_add_cad",   32'(bus.out_cad), 32'd4);

    // Asynchronous reset while a bundle is held.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",   32'(bus.out_valid), 32'd0);
    chk("arst_stall",   32'(bus.stall_cnt), 32'd0);
    chk("arst_cad",     32'(bus.out_cad), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_inst_decoder.md
Name: pipelined_inst_decoder

Overview:
- Registered MIPS decode stage between fetch and execute.
- Decodes one 32-bit instruction per cycle into the standard control-field set (ALU, GPR, BCE, memory, shifter, PC mux).
- Holds the result in a valid/ready pipeline register.
- Detects load-use hazards against the instruction it holds and inserts a parametrised number of bubbles; supports flush and a saturating stall counter.

Parameters:
HAZARD_BUBBLES, 1, bubble cycles inserted after a load when the next instruction depends on it; 0 disables hazard logic; legal 0..3
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers in_instr
in_ready  out  1  decoder accepts in_instr this cycle
in_instr  in  32  instruction word
flush  in  1  kill held instruction and pending bubbles
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes bundle
out_af  out  4  ALU function
out_i  out  1  immediate-ALU op
out_alu_mux_sel  out  1  ALU result select
out_cad  out  5  GPR write address
out_gp_we  out  1  GPR write enable
out_gp_mux_sel  out  2  GPR write-data select
out_bf  out  4  branch condition function
out_dm_we  out  1  data memory write
out_shift_type  out  3  shifter mode
out_pc_mux_sel  out  2  next-PC select
out_rs, out_rt  out  5 each  source registers
out_sa  out  5  shift amount
out_imm  out  16  immediate
out_iindex  out  26  jump index
stall_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (async, rst_n=0): all out_* = 0, out_valid=0, stall_cnt=0, state RUN.
- Decode, combinational on in_instr, with opc=[31:26], fun=[5:0]:
  - rtype = opc 000000|010000; jtype = opc 00001x; itype otherwise.
  - af[2:0] = rtype ? fun[2:0] : opc[2:0]; af[3] = rtype ? fun[3] : opc[2]&opc[1].
  - i = itype & opc[5:3]==001; alu_mux_sel = rtype & fun[5:4]==10.
  - shift_type = {1'b0, fun[1:0]}; bf = {opc[2:0], rt[0]}; dm_we = opc==101011.
  - cad = 31 for opc 000011, else rd if rtype, else rt.
  - gp_we = opc[5:3]==100 | i | alu_mux_sel | opc==000011 | rtype & fun∈{001001,000010,000011,000000}.
  - gp_mux_sel: 00 for ALU ops (alu_mux_sel|i); 01 for opc 100011; 10 for rtype fun∈{0,1,2,4,6,7}; else 11.
  - pc_mux_sel: 00 for rtype fun[5:2]==0010; 01 for itype opc[5:3]==000; 10 for jtype; else 11.
- Handshake:
  - Register loads when in_valid & in_ready; latency 1 cycle.
  - Bundle is held stable while out_valid & !out_ready.
  - out_valid drops after a transfer with no new input.
- in_ready = state==RUN & (!out_valid | out_ready) & !hazard & !flush.
- hazard = HAZARD_BUBBLES>0 & out_valid & held opc==100011 & out_cad!=0 & in_valid & (in rs==out_cad | reads_rt & in rt==out_cad).
  - reads_rt = rtype | opc==101011 | opc[5:3]==000.
- FSM:
  - RUN: if hazard & out_ready: load leaves, out_valid:=0, go BUBBLE, counter:=HAZARD_BUBBLES-1.
  - BUBBLE: in_ready=0, out_valid=0, stall_cnt+1 per cycle; when counter==0 go RUN, else decrement.
  - If hazard & !out_ready: simply hold; no bubble counted.
- flush (highest priority): next cycle out_valid=0, state RUN, counter cleared; input not accepted in the flush cycle.
- stall_cnt saturates at all-ones.

Optional Feature:
- Macro ID_SKID_BUF_EN.
- Defined:
  - One-entry skid buffer; in_ready is registered and independent of out_ready.
  - A beat accepted while the output stalls is parked in the skid buffer and issued next.
  - flush empties both entries.
- Undefined: in_ready combinationally depends on out_ready as above.

Decomposition:
- Package decoder_pkg holds:
  - opcode constants (OPC_RTYPE, OPC_COP0, OPC_J, OPC_JAL, OPC_LW, OPC_SW);
  - function constants;
  - FSM state typedef {RUN, BUBBLE};
  - packed struct dec_bundle_t of all out fields.
- Sub-module inst_decode_comb holds the pure combinational decode, instantiated once, or twice with the skid buffer.

Test Plan:
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0, stall_cnt=0 immediately, no clock needed.
- in_instr=0x8C220004 (lw $2,4($1)) -> next cycle out_gp_mux_sel=01, out_cad=2, out_gp_we=1, out_i=0.
- lw $2 held, next instr 0x00432020 (add $4,$2,$3), out_ready=1, HAZARD_BUBBLES=2 -> two cycles out_valid=0, in_ready=0; add issues cycle 3; stall_cnt=2.
- Same pair with lw writing $0 -> no bubble, stall_cnt unchanged.
- out_ready=0 for 3 cycles with in_valid=1 -> bundle stable, in_ready=0 (with ID_SKID_BUF_EN: one extra beat accepted, then in_ready=0).
- flush asserted during BUBBLE -> next cycle state RUN, out_valid=0, in_ready=1.
- jal 0x0C000010 -> out_cad=31, out_pc_mux_sel=10, out_gp_we=1, out_iindex=0x10.
